// File: rtl/pipe_pkg.sv
// Shared defaults for the arithmetic pipeline result sink.
// Count width helper sizes a counter that must reach DEPTH itself.
package pipe_pkg;

    localparam int N_DEF     = 10;
    localparam int LAT_DEF   = 3;
    localparam int DEPTH_DEF = 4;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_result_sink_if.sv
// Issue handshake, pipeline result and drain handshake of the sink.
// The slave side is the sink; the master side is source plus consumer.
interface pipe_result_sink_if #(
    parameter int N     = pipe_pkg::N_DEF,
    parameter int DEPTH = pipe_pkg::DEPTH_DEF
);
    localparam int CW = pipe_pkg::cnt_w(DEPTH);

    logic          issue_valid;
    logic          issue_ready;
    logic [N-1:0]  f_in;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic [CW-1:0] count;
    logic          drop_err;

    modport master (
        output issue_valid, f_in, out_ready,
        input  issue_ready, out_valid, out_data,
        input  count, drop_err
    );

    modport slave (
        input  issue_valid, f_in, out_ready,
        output issue_ready, out_valid, out_data,
        output count, drop_err
    );
endinterface

// File: rtl/pipe_result_sink_sync_fifo.sv
// Small synchronous FIFO with naturally wrapping pointers.
// Callers never push when full nor pop when empty.
module sync_fifo
    import pipe_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [N-1:0]  i_din,
    output logic [N-1:0]  o_dout,
    output logic [CW-1:0] o_count
);
    localparam logic [AW-1:0] P_ONE = AW'(1);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    logic [N-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push)
                r_wr_ptr <= r_wr_ptr + P_ONE;
            if (i_pop)
                r_rd_ptr <= r_rd_ptr + P_ONE;
            if (i_push && !i_pop)
                r_count <= r_count + C_ONE;
            else if (i_pop && !i_push)
                r_count <= r_count - C_ONE;
        end
    end

    // Storage carries no reset; validity comes from the count.
    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/pipe_result_sink.sv
// Tracks issues through a LAT-deep valid line and queues aligned results.
// Credits bound in-flight plus stored results by the FIFO depth.
module pipe_result_sink
    import pipe_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int LAT   = LAT_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int CW   = cnt_w(DEPTH)
) (
    input logic clk,
    input logic rst,
    pipe_result_sink_if.slave bus
);
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [CW-1:0] C_MAX = CW'(DEPTH);

    logic [LAT-1:0] r_vld_sr;
    logic [CW-1:0]  r_credits;
    logic           r_drop_err;

    logic           w_accept;
    logic           w_pop;
    logic           w_push;
    logic           w_ready;
    logic           w_out_valid;
    logic [CW-1:0]  w_count;
    logic [N-1:0]   w_dout;

    assign w_ready     = (r_credits != '0);
    assign w_accept    = bus.issue_valid & w_ready;
    assign w_out_valid = (w_count != '0);
    assign w_pop       = w_out_valid & bus.out_ready;
    assign w_push      = r_vld_sr[LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_sr <= '0;
        end else begin
            r_vld_sr[0] <= w_accept;
            for (int k = 1; k < LAT; k++)
                r_vld_sr[k] <= r_vld_sr[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credits  <= C_MAX;
            r_drop_err <= 1'b0;
        end else begin
            if (w_accept && !w_pop)
                r_credits <= r_credits - C_ONE;
            else if (w_pop && !w_accept)
                r_credits <= r_credits + C_ONE;
            if (bus.issue_valid && !w_ready)
                r_drop_err <= 1'b1;
        end
    end

    sync_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (bus.f_in),
        .o_dout  (w_dout),
        .o_count (w_count)
    );

    assign bus.issue_ready = w_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_data    = w_dout;
    assign bus.count       = w_count;
    assign bus.drop_err    = r_drop_err;

    // Credits should make this unreachable.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (rst)
        !(w_push && (w_count == C_MAX))
    );

endmodule
